// File: rtl/sha512_modq_arb_pkg.sv
// Shared widths and state encoding for the sha512_modq requester arbiter.
package sha512_modq_arb_pkg;

  localparam int SHA_BLK_W = 1024;
  localparam int SHA_CNT_W = 4;
  localparam int MODQ_W    = 256;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

endpackage

// File: rtl/sha512_modq_arb_if.sv
// Link between the arbiter and one sha512_modq core: block request side (m_*)
// and result side (s_*).
interface sha512_modq_arb_if #(
  parameter int META_W = 64,
  parameter int ID_W   = 2
) ();
  import sha512_modq_arb_pkg::*;

  logic                     m_v;
  logic                     m_f;
  logic [SHA_CNT_W-1:0]     m_c;
  logic [SHA_BLK_W-1:0]     m_d;
  logic [META_W+ID_W-1:0]   m_t;
  logic                     m_p;

  logic                     s_v;
  logic [META_W+ID_W-1:0]   s_t;
  logic [MODQ_W-1:0]        s_d;

  // Arbiter side: drives blocks, receives stall and results.
  modport master (
    output m_v, m_f, m_c, m_d, m_t,
    input  m_p,
    input  s_v, s_t, s_d
  );

  // Core side: consumes blocks, returns stall and results.
  modport slave (
    input  m_v, m_f, m_c, m_d, m_t,
    output m_p,
    output s_v, s_t, s_d
  );

endinterface

// File: rtl/sha512_modq_arb_rr_pick.sv
// Round-robin pick: first asserted request at ptr, ptr+1, ... wrapping at N.
module rr_pick #(
  parameter  int N    = 4,
  localparam int ID_W = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [ID_W-1:0] ptr,
  output logic            gnt_v,
  output logic [ID_W-1:0] gnt_idx
);

  int idx;

  // Scan in reverse priority order so the last hit, nearest to ptr, wins.
  always_comb begin
    gnt_v   = 1'b0;
    gnt_idx = '0;
    idx     = 0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = (int'(ptr) + i) % N;
      if (req[idx]) begin
        gnt_v   = 1'b1;
        gnt_idx = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/sha512_modq_arb.sv
// Shares one sha512_modq among N_REQ requesters: per-transaction round-robin
// grant locked until the last block, id-tagged metadata, results routed back.
module sha512_modq_arb
  import sha512_modq_arb_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int META_W   = 64,
  parameter int MAX_BLKS = 11
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [N_REQ-1:0]            r_v,
  input  logic [N_REQ-1:0]            r_f,
  input  logic [N_REQ*SHA_CNT_W-1:0]  r_c,
  input  logic [N_REQ*SHA_BLK_W-1:0]  r_d,
  input  logic [N_REQ*META_W-1:0]     r_t,
  output logic [N_REQ-1:0]            r_p,
  sha512_modq_arb_if.master           mq,
  output logic [N_REQ-1:0]            q_v,
  output logic [META_W-1:0]           q_t,
  output logic [MODQ_W-1:0]           q_d,
  output logic                        err
);

  localparam int ID_W = $clog2(N_REQ);
  localparam logic [SHA_CNT_W-1:0] MAX_C = SHA_CNT_W'(MAX_BLKS);
  localparam logic [SHA_CNT_W-1:0] ONE_C = SHA_CNT_W'(1);

  state_t               state;
  logic                 rdy;
  logic [ID_W-1:0]      ptr;
  logic [ID_W-1:0]      owner;
  logic [SHA_CNT_W-1:0] rem;

  logic                 hold;
  logic [N_REQ-1:0]     cand;
  logic                 gnt_v;
  logic [ID_W-1:0]      gnt_idx;
  logic [ID_W-1:0]      sel;
  logic [SHA_CNT_W-1:0] sel_c;
  logic [SHA_CNT_W-1:0] c_eff;
  logic                 first_bad;
  logic                 acc_first;
  logic                 acc_next;
  logic                 acc_drop;

  logic [ID_W-1:0]      res_id;
  logic                 res_id_ok;
  logic [N_REQ-1:0]     q_v_nxt;

  // A first block still waiting on the core keeps the output register busy.
  assign hold = mq.m_v & mq.m_f & mq.m_p;
  assign cand = r_v & r_f;

  rr_pick #(.N(N_REQ)) u_pick (
    .req     (cand),
    .ptr     (ptr),
    .gnt_v   (gnt_v),
    .gnt_idx (gnt_idx)
  );

  // Decide which requester is served this cycle and what kind of block it is.
  always_comb begin
    r_p       = '1;
    acc_first = 1'b0;
    acc_next  = 1'b0;
    acc_drop  = 1'b0;
    sel       = (state == IDLE) ? gnt_idx : owner;
    sel_c     = r_c[sel*SHA_CNT_W +: SHA_CNT_W];
    c_eff     = (sel_c == '0) ? ONE_C : sel_c;
    first_bad = (sel_c == '0) || (sel_c > MAX_C);
    if (rdy && !hold) begin
      if (state == IDLE) begin
        if (gnt_v) begin
          r_p[gnt_idx] = 1'b0;
          acc_first    = 1'b1;
        end
      end else begin
        r_p[owner] = 1'b0;
        if (r_v[owner]) begin
          if (r_f[owner]) acc_drop = 1'b1;
          else            acc_next = 1'b1;
        end
      end
    end
  end

  // Grant lock: track owner, remaining blocks and the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      rdy   <= 1'b0;
      ptr   <= '0;
      owner <= '0;
      rem   <= '0;
    end else begin
      rdy <= 1'b1;
      if (acc_first) begin
        owner <= gnt_idx;
        ptr   <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
        if (c_eff != ONE_C) begin
          rem   <= c_eff - 1'b1;
          state <= BUSY;
        end
      end else if (acc_next) begin
        rem <= rem - 1'b1;
        if (rem == ONE_C) state <= IDLE;
      end
    end
  end

  // Output register toward the core; a stray first block in BUSY is swallowed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.m_v <= 1'b0;
      mq.m_f <= 1'b0;
      mq.m_c <= '0;
      mq.m_d <= '0;
      mq.m_t <= '0;
    end else if (!hold) begin
      if (acc_first || acc_next) begin
        mq.m_v <= 1'b1;
        mq.m_f <= acc_first;
        mq.m_c <= sel_c;
        mq.m_d <= r_d[sel*SHA_BLK_W +: SHA_BLK_W];
        mq.m_t <= {sel, r_t[sel*META_W +: META_W]};
      end else begin
        mq.m_v <= 1'b0;
      end
    end
  end

  // Decode the owner id carried back on the result tag.
  always_comb begin
    res_id    = mq.s_t[META_W +: ID_W];
    res_id_ok = 1'b0;
    q_v_nxt   = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (res_id == ID_W'(i)) begin
        res_id_ok  = 1'b1;
        q_v_nxt[i] = mq.s_v;
      end
    end
  end

  // Result path: one-cycle registered broadcast with a per-owner valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_v <= '0;
      q_t <= '0;
      q_d <= '0;
    end else begin
      q_v <= q_v_nxt;
      q_t <= mq.s_t[0 +: META_W];
      q_d <= mq.s_d;
    end
  end

  // Sticky protocol error from bad counts, stray first blocks or bad result ids.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if ((acc_first && first_bad) || acc_drop || (mq.s_v && !res_id_ok)) begin
      err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sha512_modq_arb.sv
// Self-checking bench for sha512_modq_arb: scoreboarded block stream toward
// the core, table-driven single-requester transactions and hand-written
// sequences for reset, locking, backpressure, errors and result routing.
module tb_sha512_modq_arb;
  import sha512_modq_arb_pkg::*;

  localparam int N  = 4;
  localparam int MW = 64;

  typedef struct {
    logic [1:0]  id;
    logic [63:0] meta;
    logic        f;
    logic [3:0]  c;
    logic [63:0] dat;
  } sb_t;

  typedef struct {
    int          req;
    logic [3:0]  cnt;
    logic [63:0] meta;
    logic        exp_err;
  } vec_t;

  logic               clk;
  logic               rst_n;
  logic [N-1:0]       r_v, r_f, r_p, q_v;
  logic [N*4-1:0]     r_c;
  logic [N*1024-1:0]  r_d;
  logic [N*MW-1:0]    r_t;
  logic [MW-1:0]      q_t;
  logic [255:0]       q_d;
  logic               err;

  logic [2:0]         r3_v, r3_f, r3_p, q3_v;
  logic [11:0]        r3_c;
  logic [3*1024-1:0]  r3_d;
  logic [3*MW-1:0]    r3_t;
  logic [MW-1:0]      q3_t;
  logic [255:0]       q3_d;
  logic               err3;

  int  checks = 0;
  int  errors = 0;
  sb_t sb_q[$];
  sb_t mon_e;

  sha512_modq_arb_if #(.META_W(MW), .ID_W(2)) mq_if ();
  sha512_modq_arb_if #(.META_W(MW), .ID_W(2)) mq3_if ();

  sha512_modq_arb #(.N_REQ(N), .META_W(MW), .MAX_BLKS(11)) u_dut (
    .clk(clk), .rst_n(rst_n), .r_v(r_v), .r_f(r_f), .r_c(r_c), .r_d(r_d),
    .r_t(r_t), .r_p(r_p), .mq(mq_if), .q_v(q_v), .q_t(q_t), .q_d(q_d), .err(err)
  );

  sha512_modq_arb #(.N_REQ(3), .META_W(MW), .MAX_BLKS(11)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .r_v(r3_v), .r_f(r3_f), .r_c(r3_c), .r_d(r3_d),
    .r_t(r3_t), .r_p(r3_p), .mq(mq3_if), .q_v(q3_v), .q_t(q3_t), .q_d(q3_d), .err(err3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void sbPush(input int id, input logic [63:0] meta, input logic f,
                                 input logic [3:0] c, input logic [63:0] dat);
    sb_t e;
    e.id = 2'(id); e.meta = meta; e.f = f; e.c = c; e.dat = dat;
    sb_q.push_back(e);
  endfunction

  // Drive one block on requester req, wait for its grant, then withdraw it.
  task automatic applyStimulus(input int req, input logic first, input logic [3:0] c,
                               input logic [63:0] meta, input logic [63:0] dat, input bit expect_out);
    int n;
    r_v[req] = 1'b1;
    r_f[req] = first;
    r_c[req*4 +: 4] = c;
    r_t[req*MW +: MW] = meta;
    r_d[req*1024 +: 1024] = {960'b0, dat};
    if (expect_out) sbPush(req, meta, first, c, dat);
    #1;
    n = 0;
    while (r_p[req] && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 100) checkOutput("grant_timeout", 128'(r_p), 128'(~(4'b1 << req)));
    @(posedge clk); #1;
    r_v[req] = 1'b0;
    r_f[req] = 1'b0;
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    r_v = '0; r_f = '0;
    mq_if.m_p = 1'b0; mq_if.s_v = 1'b0;
    sb_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic drainCheck(input string name);
    @(negedge clk); #1;
    checkOutput(name, 128'(sb_q.size()), 128'd0);
  endtask

  // Scoreboard: every block the core takes must be the next expected one.
  always @(negedge clk) begin
    if (rst_n && mq_if.m_v && !(mq_if.m_f && mq_if.m_p)) begin
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL sb_unexpected: got block id %0d meta %0h, expected none",
                 mq_if.m_t[65:64], mq_if.m_t[63:0]);
      end else begin
        mon_e = sb_q.pop_front();
        checkOutput("sb_id",   128'(mq_if.m_t[65:64]), 128'(mon_e.id));
        checkOutput("sb_meta", 128'(mq_if.m_t[63:0]),  128'(mon_e.meta));
        checkOutput("sb_first",128'(mq_if.m_f),        128'(mon_e.f));
        checkOutput("sb_cnt",  128'(mq_if.m_c),        128'(mon_e.c));
        checkOutput("sb_data", 128'(mq_if.m_d[127:0]), 128'(mon_e.dat));
      end
    end
  end

  initial begin
    vec_t vecs[6];
    int   order[5];
    int   n, cyc, low, nb;

    vecs[0] = '{req: 1, cnt: 4'd1,  meta: 64'h1111, exp_err: 1'b0};
    vecs[1] = '{req: 3, cnt: 4'd2,  meta: 64'h3333, exp_err: 1'b0};
    vecs[2] = '{req: 0, cnt: 4'd11, meta: 64'h0B0B, exp_err: 1'b0};
    vecs[3] = '{req: 2, cnt: 4'd1,  meta: 64'h2222, exp_err: 1'b0};
    vecs[4] = '{req: 1, cnt: 4'd0,  meta: 64'h1010, exp_err: 1'b1};
    vecs[5] = '{req: 2, cnt: 4'd12, meta: 64'h2C2C, exp_err: 1'b1};
    order   = '{0, 1, 2, 3, 0};

    r3_v = '0; r3_f = '0; r3_c = '0; r3_d = '0; r3_t = '0;
    mq3_if.m_p = 1'b0; mq3_if.s_v = 1'b0; mq3_if.s_t = '0; mq3_if.s_d = '0;
    mq_if.m_p = 1'b0; mq_if.s_v = 1'b0; mq_if.s_t = '0; mq_if.s_d = '0;
    r_d = '0;

    // Reset release with everyone requesting, then round-robin fairness.
    $display("[TB] reset release and round robin");
    rst_n = 1'b1;
    r_v = 4'b1111; r_f = 4'b1111;
    for (int i = 0; i < N; i++) begin
      r_c[i*4 +: 4] = 4'd1;
      r_t[i*MW +: MW] = 64'h100 + 64'(i);
      r_d[i*1024 +: 1024] = 1024'(i);
    end
    for (int k = 0; k < 5; k++) sbPush(order[k], 64'h100 + 64'(order[k]), 1'b1, 4'd1, 64'(order[k]));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_rp",  128'(r_p), 128'hF);
    checkOutput("rst_mv",  128'(mq_if.m_v), 128'd0);
    checkOutput("rst_qv",  128'(q_v), 128'd0);
    checkOutput("rst_err", 128'(err), 128'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1 checkOutput("rdy_gate_rp", 128'(r_p), 128'hF);
    @(posedge clk); #1;
    checkOutput("first_grant_rp", 128'(r_p), 128'hE);
    n = 0; cyc = 0;
    while (n < 5 && cyc < 20) begin
      low = -1;
      for (int i = N - 1; i >= 0; i--) if (!r_p[i]) low = i;
      if (low >= 0) begin
        checkOutput("rr_grant", 128'(low), 128'(order[n]));
        n++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    r_v = '0; r_f = '0;
    if (n < 5) checkOutput("rr_timeout", 128'(n), 128'd5);
    drainCheck("rr_drain");
    checkOutput("rr_err", 128'(err), 128'd0);

    // Table of single-requester transactions, including count boundaries.
    $display("[TB] table-driven transactions");
    applyReset();
    for (int v = 0; v < 6; v++) begin
      nb = (vecs[v].cnt == 4'd0) ? 1 : int'(vecs[v].cnt);
      for (int b = 0; b < nb; b++)
        applyStimulus(vecs[v].req, b == 0, vecs[v].cnt, vecs[v].meta + 64'(b),
                      vecs[v].meta ^ 64'(b * 7 + 1), 1'b1);
      checkOutput("tbl_err", 128'(err), 128'(vecs[v].exp_err));
    end
    drainCheck("tbl_drain");

    // Lock and backpressure: req2 holds the grant while its first block stalls.
    $display("[TB] lock and backpressure");
    applyReset();
    mq_if.m_p = 1'b1;
    r_v[2] = 1'b1; r_f[2] = 1'b1; r_c[8 +: 4] = 4'd3;
    r_t[2*MW +: MW] = 64'hA0; r_d[2*1024 +: 1024] = 1024'h0A0;
    sbPush(2, 64'hA0, 1'b1, 4'd3, 64'h0A0);
    #1 checkOutput("lock_rp_idle", 128'(r_p), 128'hB);
    @(posedge clk); #1;
    r_f[2] = 1'b0; r_t[2*MW +: MW] = 64'hA1; r_d[2*1024 +: 1024] = 1024'h0A1;
    sbPush(2, 64'hA1, 1'b0, 4'd3, 64'h0A1);
    sbPush(2, 64'hA2, 1'b0, 4'd3, 64'h0A2);
    r_v[1] = 1'b1; r_f[1] = 1'b1; r_c[4 +: 4] = 4'd1;
    r_t[MW +: MW] = 64'hB0; r_d[1024 +: 1024] = 1024'h0B0;
    sbPush(1, 64'hB0, 1'b1, 4'd1, 64'h0B0);
    #1;
    for (int k = 0; k < 3; k++) begin
      checkOutput("hold_mv", 128'(mq_if.m_v), 128'd1);
      checkOutput("hold_id", 128'(mq_if.m_t[65:64]), 128'd2);
      checkOutput("hold_rp", 128'(r_p), 128'hF);
      if (k < 2) begin @(posedge clk); #1; end
    end
    mq_if.m_p = 1'b0;
    @(posedge clk); #1;
    mq_if.m_p = 1'b1;
    r_t[2*MW +: MW] = 64'hA2; r_d[2*1024 +: 1024] = 1024'h0A2;
    #1 checkOutput("lock_busy_rp", 128'(r_p), 128'hB);
    @(posedge clk); #1;
    r_v[2] = 1'b0;
    #1 checkOutput("lock_release_rp", 128'(r_p), 128'hD);
    @(posedge clk); #1;
    r_v[1] = 1'b0; r_f[1] = 1'b0;
    checkOutput("lock_req1_id", 128'(mq_if.m_t[65:64]), 128'd1);
    checkOutput("lock_req1_f",  128'(mq_if.m_f), 128'd1);
    mq_if.m_p = 1'b0;
    drainCheck("lock_drain");

    // Owner sends a first block mid-transaction: flagged and dropped.
    $display("[TB] protocol errors");
    applyReset();
    applyStimulus(0, 1'b1, 4'd2, 64'hC0, 64'hC0, 1'b1);
    checkOutput("perr_before", 128'(err), 128'd0);
    applyStimulus(0, 1'b1, 4'd2, 64'hC9, 64'hC9, 1'b0);
    checkOutput("perr_rise", 128'(err), 128'd1);
    applyStimulus(0, 1'b0, 4'd2, 64'hC1, 64'hC1, 1'b1);
    drainCheck("perr_drain");
    checkOutput("perr_sticky", 128'(err), 128'd1);

    // Result routing on the 4-requester and 3-requester instances.
    $display("[TB] result routing");
    applyReset();
    for (int k = 0; k < 4; k++) begin
      mq_if.s_v = 1'b1;
      mq_if.s_t = {2'(3 - k), 64'hABCD + 64'(k)};
      mq_if.s_d = 256'h5 + 256'(k);
      @(posedge clk); #1;
      checkOutput("route_qv", 128'(q_v), 128'(4'b1000 >> k));
      checkOutput("route_qt", 128'(q_t), 128'(64'hABCD + 64'(k)));
      checkOutput("route_qd", q_d[127:0], 128'h5 + 128'(k));
    end
    mq_if.s_v = 1'b0;
    @(posedge clk); #1;
    checkOutput("route_idle_qv", 128'(q_v), 128'd0);
    checkOutput("route_err", 128'(err), 128'd0);
    mq3_if.s_v = 1'b1; mq3_if.s_t = {2'd2, 64'h77}; mq3_if.s_d = 256'h9;
    @(posedge clk); #1;
    checkOutput("n3_route_qv", 128'(q3_v), 128'h4);
    checkOutput("n3_route_err", 128'(err3), 128'd0);
    mq3_if.s_t = {2'd3, 64'h78};
    @(posedge clk); #1;
    mq3_if.s_v = 1'b0;
    checkOutput("n3_bad_qv", 128'(q3_v), 128'd0);
    checkOutput("n3_bad_err", 128'(err3), 128'd1);

    // Reset in the middle of a 5-block transaction aborts it.
    $display("[TB] reset mid-transaction");
    applyReset();
    mq_if.s_v = 1'b1; mq_if.s_t = {2'd1, 64'h55}; mq_if.s_d = 256'h1;
    applyStimulus(1, 1'b1, 4'd5, 64'hD0, 64'hD0, 1'b1);
    checkOutput("mid_qv_before", 128'(q_v), 128'h2);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_mv", 128'(mq_if.m_v), 128'd0);
    checkOutput("mid_rst_qv", 128'(q_v), 128'd0);
    mq_if.s_v = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    r_v = 4'b1001; r_f = 4'b1001;
    r_c[0 +: 4] = 4'd1; r_c[12 +: 4] = 4'd1;
    r_t[0 +: MW] = 64'hE0; r_d[0 +: 1024] = 1024'h0E0;
    sbPush(0, 64'hE0, 1'b1, 4'd1, 64'h0E0);
    #1 checkOutput("post_rst_rp", 128'(r_p), 128'hE);
    @(posedge clk); #1;
    r_v = '0; r_f = '0;
    r_v[2] = 1'b1; r_f[2] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checkOutput("idle_nonfirst_rp", 128'(r_p), 128'hF);
    end
    r_v = '0;
    checkOutput("idle_nonfirst_err", 128'(err), 128'd0);
    drainCheck("mid_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
